// File: rtl/seed_g_func_pipe_if.sv
// Handshake bundle for seed_g_func_pipe: input beat channel, output beat channel and delivered-beat count.
// The master side is the upstream/downstream environment; the slave side is the G-function engine.
interface seed_g_func_pipe_if #(
    parameter int LANES = 1,
    parameter int CNT_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   out_data;
    logic [CNT_W-1:0]      count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/seed_g_func_pipe.sv
// Pipelined multi-lane SEED G-function (Y = SS0[x0]^SS1[x1]^SS2[x2]^SS3[x3]) with valid/ready handshake.
// Macro SEED_G_LUT_REG_EN adds a register between the SS lookups and the XOR (latency 3 instead of 2).
module seed_g_func_pipe #(
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    seed_g_func_pipe_if.slave bus
);
    localparam int DW = 32 * LANES;

    // SS0/SS1 are masked copies of S1/S2; SS2/SS3 are SS0/SS1 rotated by 16.
    localparam logic [7:0] S1_BOX [256] = '{
        8'ha9, 8'h85, 8'hd6, 8'hd3, 8'h54, 8'h1d, 8'hac, 8'h25, 8'h5d, 8'h43, 8'h18, 8'h1e, 8'h51, 8'hfc, 8'hca, 8'h63,
        8'h28, 8'h44, 8'h20, 8'h9d, 8'he0, 8'he2, 8'hc8, 8'h17, 8'ha5, 8'h8f, 8'h03, 8'h7b, 8'hbb, 8'h13, 8'hd2, 8'hee,
        8'h70, 8'h8c, 8'h3f, 8'ha8, 8'h32, 8'hdd, 8'hf6, 8'h74, 8'hec, 8'h95, 8'h0b, 8'h57, 8'h5c, 8'h5b, 8'hbd, 8'h01,
        8'h24, 8'h1c, 8'h73, 8'h98, 8'h10, 8'hcc, 8'hf2, 8'hd9, 8'h2c, 8'he7, 8'h72, 8'h83, 8'h9b, 8'hd1, 8'h86, 8'hc9,
        8'h60, 8'h50, 8'ha3, 8'heb, 8'h0d, 8'hb6, 8'h9e, 8'h4f, 8'hb7, 8'h5a, 8'hc6, 8'h78, 8'ha6, 8'h12, 8'haf, 8'hd5,
        8'h61, 8'hc3, 8'hb4, 8'h41, 8'h52, 8'h7d, 8'h8d, 8'h08, 8'h1f, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hf7, 8'he1,
        8'hfd, 8'h76, 8'h2f, 8'h27, 8'hb0, 8'h8b, 8'h0e, 8'hab, 8'ha2, 8'h6e, 8'h93, 8'h4d, 8'h69, 8'h7c, 8'h09, 8'h0a,
        8'hbf, 8'hef, 8'hf3, 8'hc5, 8'h87, 8'h14, 8'hfe, 8'h64, 8'hde, 8'h2e, 8'h4b, 8'h1a, 8'h06, 8'h21, 8'h6b, 8'h66,
        8'h02, 8'hf5, 8'h92, 8'h8a, 8'h0c, 8'hb3, 8'h7e, 8'hd0, 8'h7a, 8'h47, 8'h96, 8'he5, 8'h26, 8'h80, 8'had, 8'hdf,
        8'ha1, 8'h30, 8'h37, 8'hae, 8'h36, 8'h15, 8'h22, 8'h38, 8'hf4, 8'ha7, 8'h45, 8'h4c, 8'h81, 8'he9, 8'h84, 8'h97,
        8'h35, 8'hcb, 8'hce, 8'h3c, 8'h71, 8'h11, 8'hc7, 8'h89, 8'h75, 8'hfb, 8'hda, 8'hf8, 8'h94, 8'h59, 8'h82, 8'hc4,
        8'hff, 8'h49, 8'h39, 8'h67, 8'hc0, 8'hcf, 8'hd7, 8'hb8, 8'h0f, 8'h8e, 8'h42, 8'h23, 8'h91, 8'h6c, 8'hdb, 8'ha4,
        8'h34, 8'hf1, 8'h48, 8'hc2, 8'h6f, 8'h3d, 8'h2d, 8'h40, 8'hbe, 8'h3e, 8'hbc, 8'hc1, 8'haa, 8'hba, 8'h4e, 8'h55,
        8'h3b, 8'hdc, 8'h68, 8'h7f, 8'h9c, 8'hd8, 8'h4a, 8'h56, 8'h77, 8'ha0, 8'hed, 8'h46, 8'hb5, 8'h2b, 8'h65, 8'hfa,
        8'he3, 8'hb9, 8'hb1, 8'h9f, 8'h5e, 8'hf9, 8'he6, 8'hb2, 8'h31, 8'hea, 8'h6d, 8'h5f, 8'he4, 8'hf0, 8'hcd, 8'h88,
        8'h16, 8'h3a, 8'h58, 8'hd4, 8'h62, 8'h29, 8'h07, 8'h33, 8'he8, 8'h1b, 8'h05, 8'h79, 8'h90, 8'h6a, 8'h2a, 8'h9a
    };

    localparam logic [7:0] S2_BOX [256] = '{
        8'h38, 8'he8, 8'h2d, 8'ha6, 8'hcf, 8'hde, 8'hb3, 8'hb8, 8'haf, 8'h60, 8'h55, 8'hc7, 8'h44, 8'h6f, 8'h6b, 8'h5b,
        8'hc3, 8'h62, 8'h33, 8'hb5, 8'h29, 8'ha0, 8'he2, 8'ha7, 8'hd3, 8'h91, 8'h11, 8'h06, 8'h1c, 8'hbc, 8'h36, 8'h4b,
        8'hef, 8'h88, 8'h6c, 8'ha8, 8'h17, 8'hc4, 8'h16, 8'hf4, 8'hc2, 8'h45, 8'he1, 8'hd6, 8'h3f, 8'h3d, 8'h8e, 8'h98,
        8'h28, 8'h4e, 8'hf6, 8'h3e, 8'ha5, 8'hf9, 8'h0d, 8'hdf, 8'hd8, 8'h2b, 8'h66, 8'h7a, 8'h27, 8'h2f, 8'hf1, 8'h72,
        8'h42, 8'hd4, 8'h41, 8'hc0, 8'h73, 8'h67, 8'hac, 8'h8b, 8'hf7, 8'had, 8'h80, 8'h1f, 8'hca, 8'h2c, 8'haa, 8'h34,
        8'hd2, 8'h0b, 8'hee, 8'he9, 8'h5d, 8'h94, 8'h18, 8'hf8, 8'h57, 8'hae, 8'h08, 8'hc5, 8'h13, 8'hcd, 8'h86, 8'hb9,
        8'hff, 8'h7d, 8'hc1, 8'h31, 8'hf5, 8'h8a, 8'h6a, 8'hb1, 8'hd1, 8'h20, 8'hd7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
        8'h07, 8'hdb, 8'h9d, 8'h99, 8'h61, 8'hbe, 8'he6, 8'h59, 8'hdd, 8'h51, 8'h90, 8'hdc, 8'h9a, 8'ha3, 8'hab, 8'hd0,
        8'h81, 8'h0f, 8'h47, 8'h1a, 8'he3, 8'hec, 8'h8d, 8'hbf, 8'h96, 8'h7b, 8'h5c, 8'ha2, 8'ha1, 8'h63, 8'h23, 8'h4d,
        8'hc8, 8'h9e, 8'h9c, 8'h3a, 8'h0c, 8'h2e, 8'hba, 8'h6e, 8'h9f, 8'h5a, 8'hf2, 8'h92, 8'hf3, 8'h49, 8'h78, 8'hcc,
        8'h15, 8'hfb, 8'h70, 8'h75, 8'h7f, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6d, 8'hc6, 8'h74, 8'hd5, 8'hb4, 8'hea, 8'h09,
        8'h76, 8'h19, 8'hfe, 8'h40, 8'h12, 8'he0, 8'hbd, 8'h05, 8'hfa, 8'h01, 8'hf0, 8'h2a, 8'h5e, 8'ha9, 8'h56, 8'h43,
        8'h85, 8'h14, 8'h89, 8'h9b, 8'hb0, 8'he5, 8'h48, 8'h79, 8'h97, 8'hfc, 8'h1e, 8'h82, 8'h21, 8'h8c, 8'h1b, 8'h5f,
        8'h77, 8'h54, 8'hb2, 8'h1d, 8'h25, 8'h4f, 8'h00, 8'h46, 8'hed, 8'h58, 8'h52, 8'heb, 8'h7e, 8'hda, 8'hc9, 8'hfd,
        8'h30, 8'h95, 8'h65, 8'h3c, 8'hb6, 8'he4, 8'hbb, 8'h7c, 8'h0e, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
        8'h37, 8'he7, 8'h24, 8'ha4, 8'hcb, 8'h53, 8'h0a, 8'h87, 8'hd9, 8'h4c, 8'h83, 8'h8f, 8'hce, 8'h3b, 8'h4a, 8'hb7
    };

    function automatic logic [31:0] rotl16(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

    function automatic logic [31:0] ss0(input logic [7:0] x);
        logic [7:0] s;
        s = S1_BOX[x];
        return {s & 8'h3f, s & 8'hcf, s & 8'hf3, s & 8'hfc};
    endfunction

    function automatic logic [31:0] ss1(input logic [7:0] x);
        logic [7:0] s;
        s = S2_BOX[x];
        return {s & 8'hfc, s & 8'h3f, s & 8'hcf, s & 8'hf3};
    endfunction

    function automatic logic [31:0] ss2(input logic [7:0] x);
        return rotl16(ss0(x));
    endfunction

    function automatic logic [31:0] ss3(input logic [7:0] x);
        return rotl16(ss1(x));
    endfunction

    logic             in_ready_c;
    logic             s1_valid;
    logic [DW-1:0]    s1_data;
    logic             pre_valid;
    logic [DW-1:0]    g_d;
    logic             out_valid_q;
    logic [DW-1:0]    out_data_q;
    logic [CNT_W-1:0] count_q;
    logic             s1_en;
    logic             s2_en;

    // A stage may load when it is empty or its content is leaving this cycle.
    assign s2_en      = !out_valid_q || bus.out_ready;
    assign in_ready_c = !s1_valid || s1_en;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
            end
        end
    end

`ifdef SEED_G_LUT_REG_EN
    logic        lut_valid;
    logic [31:0] lut_q [LANES][4];
    logic [31:0] lut_d [LANES][4];

    assign s1_en     = !lut_valid || s2_en;
    assign pre_valid = lut_valid;

    always_comb begin
        lut_d = '{default: '0};
        g_d   = '0;
        for (int k = 0; k < LANES; k++) begin
            lut_d[k][0] = ss0(s1_data[32*k      +: 8]);
            lut_d[k][1] = ss1(s1_data[32*k + 8  +: 8]);
            lut_d[k][2] = ss2(s1_data[32*k + 16 +: 8]);
            lut_d[k][3] = ss3(s1_data[32*k + 24 +: 8]);
            g_d[32*k +: 32] = lut_q[k][0] ^ lut_q[k][1] ^ lut_q[k][2] ^ lut_q[k][3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                for (int t = 0; t < 4; t++) begin
                    lut_q[k][t] <= '0;
                end
            end
        end else if (s1_en) begin
            lut_valid <= s1_valid;
            if (s1_valid) begin
                lut_q <= lut_d;
            end
        end
    end
`else
    assign s1_en     = s2_en;
    assign pre_valid = s1_valid;

    always_comb begin
        g_d = '0;
        for (int k = 0; k < LANES; k++) begin
            g_d[32*k +: 32] = ss0(s1_data[32*k      +: 8]) ^ ss1(s1_data[32*k + 8  +: 8])
                            ^ ss2(s1_data[32*k + 16 +: 8]) ^ ss3(s1_data[32*k + 24 +: 8]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (s2_en) begin
            out_valid_q <= pre_valid;
            if (pre_valid) begin
                out_data_q <= g_d;
            end
        end
    end

    // Free-running wrap is intended; the count is a delivery tally, not a limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_seed_g_func_pipe.sv
// Bench for seed_g_func_pipe: directed and random beats against a byte-level reference of the G-function.
// Two instances: 1 lane with a 4-bit counter, and 4 lanes with a 16-bit counter.
module tb_seed_g_func_pipe;
`ifdef SEED_G_LUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [7:0] S1_TAB [256] = '{
        8'ha9, 8'h85, 8'hd6, 8'hd3, 8'h54, 8'h1d, 8'hac, 8'h25, 8'h5d, 8'h43, 8'h18, 8'h1e, 8'h51, 8'hfc, 8'hca, 8'h63,
        8'h28, 8'h44, 8'h20, 8'h9d, 8'he0, 8'he2, 8'hc8, 8'h17, 8'ha5, 8'h8f, 8'h03, 8'h7b, 8'hbb, 8'h13, 8'hd2, 8'hee,
        8'h70, 8'h8c, 8'h3f, 8'ha8, 8'h32, 8'hdd, 8'hf6, 8'h74, 8'hec, 8'h95, 8'h0b, 8'h57, 8'h5c, 8'h5b, 8'hbd, 8'h01,
        8'h24, 8'h1c, 8'h73, 8'h98, 8'h10, 8'hcc, 8'hf2, 8'hd9, 8'h2c, 8'he7, 8'h72, 8'h83, 8'h9b, 8'hd1, 8'h86, 8'hc9,
        8'h60, 8'h50, 8'ha3, 8'heb, 8'h0d, 8'hb6, 8'h9e, 8'h4f, 8'hb7, 8'h5a, 8'hc6, 8'h78, 8'ha6, 8'h12, 8'haf, 8'hd5,
        8'h61, 8'hc3, 8'hb4, 8'h41, 8'h52, 8'h7d, 8'h8d, 8'h08, 8'h1f, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hf7, 8'he1,
        8'hfd, 8'h76, 8'h2f, 8'h27, 8'hb0, 8'h8b, 8'h0e, 8'hab, 8'ha2, 8'h6e, 8'h93, 8'h4d, 8'h69, 8'h7c, 8'h09, 8'h0a,
        8'hbf, 8'hef, 8'hf3, 8'hc5, 8'h87, 8'h14, 8'hfe, 8'h64, 8'hde, 8'h2e, 8'h4b, 8'h1a, 8'h06, 8'h21, 8'h6b, 8'h66,
        8'h02, 8'hf5, 8'h92, 8'h8a, 8'h0c, 8'hb3, 8'h7e, 8'hd0, 8'h7a, 8'h47, 8'h96, 8'he5, 8'h26, 8'h80, 8'had, 8'hdf,
        8'ha1, 8'h30, 8'h37, 8'hae, 8'h36, 8'h15, 8'h22, 8'h38, 8'hf4, 8'ha7, 8'h45, 8'h4c, 8'h81, 8'he9, 8'h84, 8'h97,
        8'h35, 8'hcb, 8'hce, 8'h3c, 8'h71, 8'h11, 8'hc7, 8'h89, 8'h75, 8'hfb, 8'hda, 8'hf8, 8'h94, 8'h59, 8'h82, 8'hc4,
        8'hff, 8'h49, 8'h39, 8'h67, 8'hc0, 8'hcf, 8'hd7, 8'hb8, 8'h0f, 8'h8e, 8'h42, 8'h23, 8'h91, 8'h6c, 8'hdb, 8'ha4,
        8'h34, 8'hf1, 8'h48, 8'hc2, 8'h6f, 8'h3d, 8'h2d, 8'h40, 8'hbe, 8'h3e, 8'hbc, 8'hc1, 8'haa, 8'hba, 8'h4e, 8'h55,
        8'h3b, 8'hdc, 8'h68, 8'h7f, 8'h9c, 8'hd8, 8'h4a, 8'h56, 8'h77, 8'ha0, 8'hed, 8'h46, 8'hb5, 8'h2b, 8'h65, 8'hfa,
        8'he3, 8'hb9, 8'hb1, 8'h9f, 8'h5e, 8'hf9, 8'he6, 8'hb2, 8'h31, 8'hea, 8'h6d, 8'h5f, 8'he4, 8'hf0, 8'hcd, 8'h88,
        8'h16, 8'h3a, 8'h58, 8'hd4, 8'h62, 8'h29, 8'h07, 8'h33, 8'he8, 8'h1b, 8'h05, 8'h79, 8'h90, 8'h6a, 8'h2a, 8'h9a
    };

    localparam logic [7:0] S2_TAB [256] = '{
        8'h38, 8'he8, 8'h2d, 8'ha6, 8'hcf, 8'hde, 8'hb3, 8'hb8, 8'haf, 8'h60, 8'h55, 8'hc7, 8'h44, 8'h6f, 8'h6b, 8'h5b,
        8'hc3, 8'h62, 8'h33, 8'hb5, 8'h29, 8'ha0, 8'he2, 8'ha7, 8'hd3, 8'h91, 8'h11, 8'h06, 8'h1c, 8'hbc, 8'h36, 8'h4b,
        8'hef, 8'h88, 8'h6c, 8'ha8, 8'h17, 8'hc4, 8'h16, 8'hf4, 8'hc2, 8'h45, 8'he1, 8'hd6, 8'h3f, 8'h3d, 8'h8e, 8'h98,
        8'h28, 8'h4e, 8'hf6, 8'h3e, 8'ha5, 8'hf9, 8'h0d, 8'hdf, 8'hd8, 8'h2b, 8'h66, 8'h7a, 8'h27, 8'h2f, 8'hf1, 8'h72,
        8'h42, 8'hd4, 8'h41, 8'hc0, 8'h73, 8'h67, 8'hac, 8'h8b, 8'hf7, 8'had, 8'h80, 8'h1f, 8'hca, 8'h2c, 8'haa, 8'h34,
        8'hd2, 8'h0b, 8'hee, 8'he9, 8'h5d, 8'h94, 8'h18, 8'hf8, 8'h57, 8'hae, 8'h08, 8'hc5, 8'h13, 8'hcd, 8'h86, 8'hb9,
        8'hff, 8'h7d, 8'hc1, 8'h31, 8'hf5, 8'h8a, 8'h6a, 8'hb1, 8'hd1, 8'h20, 8'hd7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
        8'h07, 8'hdb, 8'h9d, 8'h99, 8'h61, 8'hbe, 8'he6, 8'h59, 8'hdd, 8'h51, 8'h90, 8'hdc, 8'h9a, 8'ha3, 8'hab, 8'hd0,
        8'h81, 8'h0f, 8'h47, 8'h1a, 8'he3, 8'hec, 8'h8d, 8'hbf, 8'h96, 8'h7b, 8'h5c, 8'ha2, 8'ha1, 8'h63, 8'h23, 8'h4d,
        8'hc8, 8'h9e, 8'h9c, 8'h3a, 8'h0c, 8'h2e, 8'hba, 8'h6e, 8'h9f, 8'h5a, 8'hf2, 8'h92, 8'hf3, 8'h49, 8'h78, 8'hcc,
        8'h15, 8'hfb, 8'h70, 8'h75, 8'h7f, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6d, 8'hc6, 8'h74, 8'hd5, 8'hb4, 8'hea, 8'h09,
        8'h76, 8'h19, 8'hfe, 8'h40, 8'h12, 8'he0, 8'hbd, 8'h05, 8'hfa, 8'h01, 8'hf0, 8'h2a, 8'h5e, 8'ha9, 8'h56, 8'h43,
        8'h85, 8'h14, 8'h89, 8'h9b, 8'hb0, 8'he5, 8'h48, 8'h79, 8'h97, 8'hfc, 8'h1e, 8'h82, 8'h21, 8'h8c, 8'h1b, 8'h5f,
        8'h77, 8'h54, 8'hb2, 8'h1d, 8'h25, 8'h4f, 8'h00, 8'h46, 8'hed, 8'h58, 8'h52, 8'heb, 8'h7e, 8'hda, 8'hc9, 8'hfd,
        8'h30, 8'h95, 8'h65, 8'h3c, 8'hb6, 8'he4, 8'hbb, 8'h7c, 8'h0e, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
        8'h37, 8'he7, 8'h24, 8'ha4, 8'hcb, 8'h53, 8'h0a, 8'h87, 8'hd9, 8'h4c, 8'h83, 8'h8f, 8'hce, 8'h3b, 8'h4a, 8'hb7
    };

    localparam logic [7:0] MASK [4] = '{8'hfc, 8'hf3, 8'hcf, 8'h3f};

    // Output byte j collects, from every input byte i, its S-box value masked with MASK[(i+j)%4].
    function automatic logic [31:0] g_ref(input logic [31:0] x);
        logic [31:0] y;
        logic [7:0]  s;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            s = (i % 2 == 0) ? S1_TAB[x[8*i +: 8]] : S2_TAB[x[8*i +: 8]];
            for (int j = 0; j < 4; j++) begin
                y[8*j +: 8] = y[8*j +: 8] ^ (s & MASK[(i + j) % 4]);
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] g4(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 4; k++) y[32*k +: 32] = g_ref(x[32*k +: 32]);
        return y;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seed_g_func_pipe_if #(.LANES(1), .CNT_W(4))  b1 ();
    seed_g_func_pipe_if #(.LANES(4), .CNT_W(16)) b4 ();

    seed_g_func_pipe #(.LANES(1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(b1));
    seed_g_func_pipe #(.LANES(4), .CNT_W(16)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int            checks = 0;
    int            errors = 0;
    logic [127:0]  q [$];
    logic          stalled = 1'b0;
    logic [127:0]  held_data = '0;
    logic [15:0]   cnt_exp = '0;
    int            cyc = 0;
    int            ret_n = 0;
    int            first_ret = 0;
    int            last_ret = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 4-lane instance, entered and left at a falling edge.
    task automatic cycle4(input logic vin, input logic [127:0] din, input logic rdy, output logic acc);
        logic         ret;
        logic [127:0] exp;
        b4.in_valid  = vin;
        b4.in_data   = din;
        b4.out_ready = rdy;
        #1;
        if (stalled) begin
            chk("hold_valid", b4.out_valid, 1'b1);
            chk("hold_data", b4.out_data, held_data);
        end
        chk("count", b4.count, cnt_exp);
        acc = vin && b4.in_ready;
        ret = b4.out_valid && rdy;
        if (ret) begin
            chk("beat_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                exp = q.pop_front();
                chk("lane_data", b4.out_data, exp);
            end
            cnt_exp++;
            ret_n++;
            if (ret_n == 1) first_ret = cyc;
            last_ret = cyc;
        end
        if (acc) q.push_back(g4(din));
        stalled   = b4.out_valid && !rdy;
        held_data = b4.out_data;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    logic [31:0]  x;
    logic [127:0] d;
    logic         acc;
    int           acc_n;
    int           guard;
    int           k;

    initial begin
        // Reset with valid input asserted
        rst = 1'b1;
        b1.in_valid = 1'b1; b1.in_data = 32'h1234_5678; b1.out_ready = 1'b1;
        b4.in_valid = 1'b1; b4.in_data = {4{32'hdead_beef}}; b4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid1", b1.out_valid, 1'b0);
        chk("rst_data1", b1.out_data, 32'h0);
        chk("rst_count1", b1.count, 4'h0);
        chk("rst_valid4", b4.out_valid, 1'b0);
        chk("rst_data4", b4.out_data, 128'h0);
        chk("rst_count4", b4.count, 16'h0);
        rst = 1'b0;
        b1.in_valid = 1'b0;
        b4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready1", b1.in_ready, 1'b1);
        chk("post_rst_ready4", b4.in_ready, 1'b1);

        // Known vectors on the single-lane instance with exact latency
        for (int v = 0; v < 2; v++) begin
            x = (v == 0) ? 32'h0000_0000 : 32'h0000_d600;
            b1.in_valid = 1'b1;
            b1.in_data  = x;
            #1;
            chk("t2_ready", b1.in_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            b1.in_valid = 1'b0;
            for (int c = 1; c < LAT; c++) begin
                chk("t2_early", b1.out_valid, 1'b0);
                @(posedge clk);
                @(negedge clk);
            end
            chk("t2_valid", b1.out_valid, 1'b1);
            chk("t2_known", b1.out_data, (v == 0) ? 32'hb829_b829 : 32'h8011_b019);
            chk("t2_model", b1.out_data, g_ref(x));
            @(posedge clk);
            @(negedge clk);
        end
        chk("t2_count", b1.count, 4'd2);

        // 15 more beats take the 4-bit counter from 2 through 15 and wrap to 1
        b1.in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            b1.in_data = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        b1.in_valid = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        chk("t6_drained", b1.out_valid, 1'b0);
        chk("t6_wrap", b1.count, 4'd1);

        // Streaming 256 back-to-back beats
        ret_n = 0;
        for (int b = 0; b < 256; b++) begin
            x = {4{b[7:0]}};
            d = {x, x, x, x};
            cycle4(1'b1, d, 1'b1, acc);
            chk("t3_accept", acc, 1'b1);
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            cycle4(1'b0, '0, 1'b1, acc);
            guard++;
        end
        chk("t3_drain", q.size(), 0);
        chk("t3_delivered", ret_n, 256);
        chk("t3_no_bubble", last_ret - first_ret, 255);
        chk("t3_count", b4.count, 16'd256);

        // Random traffic under random backpressure
        acc_n = 0;
        guard = 0;
        while (acc_n < 1000 && guard < 20000) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle4(($urandom_range(0, 3) != 0), d, $urandom_range(0, 1) == 1, acc);
            if (acc) acc_n++;
            guard++;
        end
        chk("t4_accepted", acc_n, 1000);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            cycle4(1'b0, '0, 1'b1, acc);
            guard++;
        end
        chk("t4_drain", q.size(), 0);

        // Fill the pipe under stall, then reset it mid-stream
        for (int i = 0; i < LAT + 2; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle4(1'b1, d, 1'b0, acc);
        end
        chk("t5_capacity", q.size(), LAT);
        b4.in_valid = 1'b1;
        #1;
        chk("t5_full_not_ready", b4.in_ready, 1'b0);
        rst = 1'b1;
        b4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_valid", b4.out_valid, 1'b0);
        chk("t5_rst_count", b4.count, 16'h0);
        q.delete();
        cnt_exp = '0;
        stalled = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        cycle4(1'b1, d, 1'b1, acc);
        chk("t5_accept", acc, 1'b1);
        k = 0;
        while (b4.out_valid !== 1'b1 && k < 10) begin
            cycle4(1'b0, '0, 1'b1, acc);
            k++;
        end
        chk("t5_latency", k, LAT - 1);
        cycle4(1'b0, '0, 1'b1, acc);
        chk("t5_drain", q.size(), 0);
        chk("t5_count", b4.count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
